// File: rtl/int8_mac_pkg.sv
// Shared types for the INT8 MAC dot-product sequencer: FSM state,
// MAC pipeline latency and the per-channel requant parameter bundle.
package int8_mac_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PARAM = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Last MAC beat to mac_Q3_valid. Completion is counted on results, so
   // this is informational for integrators and models.
   localparam int MAC_LATENCY = 7;

   localparam int PRM_MO_W = 32;

   // Requant parameters of one output channel, held for all K beats.
   typedef struct packed {
      logic [PRM_MO_W-1:0] m0;
      logic [5:0]          n;
      logic signed [31:0]  bias;
      logic signed [7:0]   zo;
   } prm_t;

endpackage

// File: rtl/int8_mac_dot_sequencer_if.sv
// Memory, MAC and result-buffer bus of the dot-product sequencer.
// master = sequencer side, slave = SRAMs / MAC / result buffer side.
interface int8_mac_dot_sequencer_if #(
   parameter int MO_WIDTH = 32,
   parameter int K_W      = 12,
   parameter int CH_W     = 8,
   parameter int WA_W     = 20
);
   // activation / weight / param SRAM reads
   logic                act_re;
   logic [K_W-1:0]      act_addr;
   logic signed [7:0]   act_rdata;
   logic                wgt_re;
   logic [WA_W-1:0]     wgt_addr;
   logic signed [7:0]   wgt_rdata;
   logic                prm_re;
   logic [CH_W-1:0]     prm_addr;
   logic [MO_WIDTH-1:0] prm_M0;
   logic [5:0]          prm_n;
   logic signed [31:0]  prm_bias;
   logic signed [7:0]   prm_Zo;
   // MAC beat
   logic signed [7:0]   mac_Qa;
   logic signed [7:0]   mac_Qw;
   logic [7:0]          mac_Za;
   logic [7:0]          mac_Zw;
   logic                mac_En;
   logic [MO_WIDTH-1:0] mac_M0;
   logic signed [7:0]   mac_Zo;
   logic [5:0]          mac_n;
   logic signed [31:0]  mac_bias;
   logic                mac_clear;
   logic                mac_last;
   logic signed [7:0]   mac_Q3;
   logic                mac_Q3_valid;
   // result buffer write port
   logic                res_we;
   logic [CH_W-1:0]     res_addr;
   logic signed [7:0]   res_data;

   modport master (
      output act_re, act_addr, wgt_re, wgt_addr, prm_re, prm_addr,
      output mac_Qa, mac_Qw, mac_Za, mac_Zw, mac_En, mac_M0, mac_Zo,
      output mac_n, mac_bias, mac_clear, mac_last,
      output res_we, res_addr, res_data,
      input  act_rdata, wgt_rdata, prm_M0, prm_n, prm_bias, prm_Zo,
      input  mac_Q3, mac_Q3_valid
   );

   modport slave (
      input  act_re, act_addr, wgt_re, wgt_addr, prm_re, prm_addr,
      input  mac_Qa, mac_Qw, mac_Za, mac_Zw, mac_En, mac_M0, mac_Zo,
      input  mac_n, mac_bias, mac_clear, mac_last,
      input  res_we, res_addr, res_data,
      output act_rdata, wgt_rdata, prm_M0, prm_n, prm_bias, prm_Zo,
      output mac_Q3, mac_Q3_valid
   );
endinterface

// File: rtl/int8_mac_result_collector.sv
// Counts MAC results and writes each one to the result buffer at the
// current count. Any valid result is written and counted, whatever the
// sequencer state; the count restarts on an accepted start.
module int8_mac_result_collector #(
   parameter int CH_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              q3_valid,
   input  logic signed [7:0] q3,
   output logic              res_we,
   output logic [CH_W-1:0]   res_addr,
   output logic signed [7:0] res_data,
   output logic [CH_W-1:0]   cnt
);
   logic [CH_W-1:0] cnt_q, cnt_d;

   // next result index: clear on a new run, bump per valid result
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (q3_valid)
         cnt_d = cnt_q + CH_W'(1);
   end

   // result counter
   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign res_we   = q3_valid;
   assign res_addr = cnt_q;
   assign res_data = q3_valid ? q3 : 8'sd0;
   assign cnt      = cnt_q;

endmodule

// File: rtl/int8_mac_dot_sequencer.sv
// Drives one pipelined INT8 MAC through N output-channel dot products of
// length K: per channel one param read, then K act/weight reads whose data
// forms the MAC beat one cycle later. Results are collected by count.
module int8_mac_dot_sequencer
   import int8_mac_pkg::*;
#(
   parameter int MO_WIDTH = 32,
   parameter int K_W      = 12,
   parameter int CH_W     = 8,
   parameter int WA_W     = 20
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic [K_W-1:0]  cfg_K,
   input  logic [CH_W-1:0] cfg_N,
   input  logic [7:0]      cfg_Za,
   input  logic [7:0]      cfg_Zw,
   output logic            busy,
   output logic            done,
   int8_mac_dot_sequencer_if.master bus
);
   state_e          state_q, state_d;
   logic [K_W-1:0]  k_q, k_d, len_q, len_d;
   logic [CH_W-1:0] ch_q, ch_d, nch_q, nch_d;
   logic [7:0]      za_q, za_d, zw_q, zw_d;
   logic [WA_W-1:0] base_q, base_d;
   prm_t            prm_q, prm_d;

   // registered outputs
   logic            busy_q, busy_d, done_q, done_d;
   logic            act_re_q, act_re_d, prm_re_q, prm_re_d;
   logic [K_W-1:0]  act_addr_q, act_addr_d;
   logic [WA_W-1:0] wgt_addr_q, wgt_addr_d;
   logic [CH_W-1:0] prm_addr_q, prm_addr_d;
   logic            en_q, en_d, clear_q, clear_d, last_q, last_d;

   logic            accept, k_last, ch_last;
   logic [CH_W-1:0] res_cnt;

   assign k_last  = (k_q == len_q - K_W'(1));
   assign ch_last = (ch_q == nch_q - CH_W'(1));

   // next state, counters, param capture and output decode
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ch_d    = ch_q;
      base_d  = base_q;
      len_d   = len_q;
      nch_d   = nch_q;
      za_d    = za_q;
      zw_d    = zw_q;
      prm_d   = prm_q;
      accept  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               len_d  = cfg_K;
               nch_d  = cfg_N;
               za_d   = cfg_Za;
               zw_d   = cfg_Zw;
               k_d    = '0;
               ch_d   = '0;
               base_d = '0;
               // empty layer: straight to DONE, no reads, no beats
               state_d = (cfg_K == '0 || cfg_N == '0) ? DONE : PARAM;
            end
         end
         PARAM: state_d = ISSUE;
         ISSUE: begin
            // param read data lands in the first issue cycle of a channel
            if (k_q == '0) begin
               prm_d.m0   = bus.prm_M0;
               prm_d.n    = bus.prm_n;
               prm_d.bias = bus.prm_bias;
               prm_d.zo   = bus.prm_Zo;
            end
            if (k_last) begin
               k_d = '0;
               if (ch_last) begin
                  state_d = DRAIN;
               end else begin
                  ch_d    = ch_q + CH_W'(1);
                  base_d  = base_q + WA_W'(len_q);
                  state_d = PARAM;
               end
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         DRAIN: if (res_cnt == nch_q) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      prm_re_d   = (state_d == PARAM);
      prm_addr_d = ch_d;
      act_re_d   = (state_d == ISSUE);
      act_addr_d = k_d;
      wgt_addr_d = base_d + WA_W'(k_d);
      // MAC beat trails the read issued this cycle (k_q is its index)
      en_d       = act_re_q;
      clear_d    = act_re_q && (k_q == '0);
      last_d     = act_re_q && k_last;
   end

   // FSM, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         k_q        <= '0;
         ch_q       <= '0;
         base_q     <= '0;
         len_q      <= '0;
         nch_q      <= '0;
         za_q       <= '0;
         zw_q       <= '0;
         prm_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         prm_re_q   <= 1'b0;
         prm_addr_q <= '0;
         act_re_q   <= 1'b0;
         act_addr_q <= '0;
         wgt_addr_q <= '0;
         en_q       <= 1'b0;
         clear_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         ch_q       <= ch_d;
         base_q     <= base_d;
         len_q      <= len_d;
         nch_q      <= nch_d;
         za_q       <= za_d;
         zw_q       <= zw_d;
         prm_q      <= prm_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         prm_re_q   <= prm_re_d;
         prm_addr_q <= prm_addr_d;
         act_re_q   <= act_re_d;
         act_addr_q <= act_addr_d;
         wgt_addr_q <= wgt_addr_d;
         en_q       <= en_d;
         clear_q    <= clear_d;
         last_q     <= last_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign bus.prm_re   = prm_re_q;
   assign bus.prm_addr = prm_addr_q;
   assign bus.act_re   = act_re_q;
   assign bus.act_addr = act_addr_q;
   assign bus.wgt_re   = act_re_q;
   assign bus.wgt_addr = wgt_addr_q;

   assign bus.mac_Qa    = bus.act_rdata;
   assign bus.mac_Qw    = bus.wgt_rdata;
   assign bus.mac_Za    = za_q;
   assign bus.mac_Zw    = zw_q;
   assign bus.mac_En    = en_q;
   assign bus.mac_clear = clear_q;
   assign bus.mac_last  = last_q;
   assign bus.mac_M0    = prm_q.m0;
   assign bus.mac_n     = prm_q.n;
   assign bus.mac_bias  = prm_q.bias;
   assign bus.mac_Zo    = prm_q.zo;

   int8_mac_result_collector #(.CH_W(CH_W)) u_collect (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (accept),
      .q3_valid (bus.mac_Q3_valid),
      .q3       (bus.mac_Q3),
      .res_we   (bus.res_we),
      .res_addr (bus.res_addr),
      .res_data (bus.res_data),
      .cnt      (res_cnt)
   );

endmodule

// File: tb/tb_int8_mac_dot_sequencer.sv
// Directed bench for the dot-product sequencer: SRAM responders, a
// behavioural 7-cycle MAC and per-scenario tasks with inline checks.
module tb_int8_mac_dot_sequencer;
   localparam int MO_WIDTH = 32;
   localparam int K_W      = 12;
   localparam int CH_W     = 8;
   localparam int WA_W     = 20;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            start = 1'b0;
   logic [K_W-1:0]  cfg_K = '0;
   logic [CH_W-1:0] cfg_N = '0;
   logic [7:0]      cfg_Za = '0;
   logic [7:0]      cfg_Zw = '0;
   logic            busy, done;

   int8_mac_dot_sequencer_if #(.MO_WIDTH(MO_WIDTH), .K_W(K_W), .CH_W(CH_W), .WA_W(WA_W)) bus ();

   int8_mac_dot_sequencer #(.MO_WIDTH(MO_WIDTH), .K_W(K_W), .CH_W(CH_W), .WA_W(WA_W)) dut (
      .CLK(CLK), .RST(RST), .start(start), .cfg_K(cfg_K), .cfg_N(cfg_N),
      .cfg_Za(cfg_Za), .cfg_Zw(cfg_Zw), .busy(busy), .done(done), .bus(bus)
   );

   always #5 CLK = ~CLK;

   // ---------------- SRAM models (1-cycle read latency) ----------------
   logic signed [7:0]  act_mem [4096];
   logic signed [7:0]  wgt_mem [64];
   logic [31:0]        pm0 [256];
   logic [5:0]         pn  [256];
   logic signed [31:0] pbias [256];
   logic signed [7:0]  pzo [256];
   logic signed [7:0]  act_rd = '0, wgt_rd = '0, pzo_rd = '0;
   logic [31:0]        pm0_rd = '0;
   logic [5:0]         pn_rd = '0;
   logic signed [31:0] pbias_rd = '0;

   always @(posedge CLK) begin
      if (bus.act_re) act_rd <= act_mem[bus.act_addr];
      if (bus.wgt_re) wgt_rd <= wgt_mem[int'(bus.wgt_addr) % 64];
      if (bus.prm_re) begin
         pm0_rd   <= pm0[bus.prm_addr];
         pn_rd    <= pn[bus.prm_addr];
         pbias_rd <= pbias[bus.prm_addr];
         pzo_rd   <= pzo[bus.prm_addr];
      end
   end
   assign bus.act_rdata = act_rd;
   assign bus.wgt_rdata = wgt_rd;
   assign bus.prm_M0    = pm0_rd;
   assign bus.prm_n     = pn_rd;
   assign bus.prm_bias  = pbias_rd;
   assign bus.prm_Zo    = pzo_rd;

   // ---------------- behavioural MAC: acc, requant, 7-cycle result -------
   function automatic logic signed [7:0] requant(input logic signed [31:0] acc,
         input logic signed [31:0] bias, input logic [31:0] m0, input logic [5:0] n,
         input logic signed [7:0] zo);
      logic signed [63:0] s, m, p;
      s = acc;
      s = s + bias;
      m = {32'd0, m0};
      p = s * m;
      p = p >>> (31 + int'(n));
      p = p + zo;
      if (p > 127)       return 8'sd127;
      else if (p < -128) return -8'sd128;
      else               return p[7:0];
   endfunction

   logic signed [31:0] m_acc = '0, m_ta, m_tw, m_next;
   logic signed [7:0]  m_q3;
   logic [6:0]         m_vld = '0;
   logic signed [7:0]  m_dat [7];

   always_comb begin
      m_ta   = 32'($signed(bus.mac_Qa)) - 32'($signed(bus.mac_Za));
      m_tw   = 32'($signed(bus.mac_Qw)) - 32'($signed(bus.mac_Zw));
      m_next = (bus.mac_clear ? 32'sd0 : m_acc) + m_ta * m_tw;
      m_q3   = requant(m_next, bus.mac_bias, bus.mac_M0, bus.mac_n, bus.mac_Zo);
   end

   always @(posedge CLK) begin
      if (RST) begin
         m_acc <= '0;
         m_vld <= '0;
      end else begin
         if (bus.mac_En) m_acc <= m_next;
         m_vld <= {m_vld[5:0], bus.mac_En & bus.mac_last};
         m_dat[0] <= m_q3;
         for (int i = 1; i < 7; i++) m_dat[i] <= m_dat[i-1];
      end
   end
   assign bus.mac_Q3       = m_dat[6];
   assign bus.mac_Q3_valid = m_vld[6];

   // ---------------- run statistics ----------------
   int n_vec = 0, n_err = 0;
   int cyc_done, n_done, n_act, n_wre, n_en, n_prm, n_issue, n_cl_same, busy_gap;
   int wa_q[$], pa_q[$], aa_q[$], ra_q[$], rd_q[$];
   logic timed_out, after_busy, after_done;

   task automatic go(input int k, input int n, input int za, input int zw);
      start  = 1'b1;
      cfg_K  = K_W'(k);
      cfg_N  = CH_W'(n);
      cfg_Za = 8'(za);
      cfg_Zw = 8'(zw);
      @(negedge CLK);
      start = 1'b0;
   endtask

   // observe one run from the cycle after start until done (bounded)
   task automatic run(input int restart_at, input int k2, input int n2);
      int i;
      bit fin;
      i = 0; fin = 1'b0;
      cyc_done = -1; n_done = 0; n_act = 0; n_wre = 0; n_en = 0; n_prm = 0;
      n_issue = 0; n_cl_same = 0; busy_gap = 0;
      wa_q.delete(); pa_q.delete(); aa_q.delete(); ra_q.delete(); rd_q.delete();
      while (!fin && i < 400) begin
         if (i == restart_at) begin
            start = 1'b1; cfg_K = K_W'(k2); cfg_N = CH_W'(n2);
         end else begin
            start = 1'b0;
         end
         if (bus.act_re) begin
            n_act++;
            aa_q.push_back(int'(bus.act_addr));
            wa_q.push_back(int'(bus.wgt_addr));
         end
         if (bus.wgt_re) n_wre++;
         if (bus.prm_re) begin
            n_prm++;
            pa_q.push_back(int'(bus.prm_addr));
         end
         if (bus.act_re || bus.prm_re) n_issue++;
         if (bus.mac_En) begin
            n_en++;
            if (bus.mac_clear && bus.mac_last) n_cl_same++;
         end
         if (bus.res_we) begin
            ra_q.push_back(int'(bus.res_addr));
            rd_q.push_back(int'(bus.res_data));
         end
         if (!busy) busy_gap++;
         if (done) begin
            n_done++;
            cyc_done = i;
            fin = 1'b1;
         end
         @(negedge CLK);
         i++;
      end
      start      = 1'b0;
      timed_out  = !fin;
      after_busy = busy;
      after_done = done;
      n_vec++;
      if (timed_out) begin
         n_err++;
         $display("FAIL run_timeout: done not seen within %0d cycles", i);
      end
   endtask

   task automatic check_results(input string tag, input int exp_d[]);
      int bad;
      bad = 0;
      for (int j = 0; j < exp_d.size(); j++) begin
         if (j >= rd_q.size() || rd_q[j] != exp_d[j] || ra_q[j] != j) bad++;
      end
      n_vec++;
      if (rd_q.size() != exp_d.size() || bad != 0) begin
         n_err++;
         $display("FAIL %s_results: got %0d writes (%0d wrong), want %0d writes, first data %0d want %0d",
                  tag, rd_q.size(), bad, exp_d.size(),
                  (rd_q.size() > 0) ? rd_q[0] : -999, exp_d[0]);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      repeat (3) @(negedge CLK);
      n_vec++;
      if ({busy, done, bus.act_re, bus.wgt_re, bus.prm_re, bus.mac_En, bus.mac_clear,
           bus.mac_last, bus.res_we} !== 9'b0) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 0", {busy, done, bus.act_re, bus.wgt_re,
                  bus.prm_re, bus.mac_En, bus.mac_clear, bus.mac_last, bus.res_we});
      end
      n_vec++;
      if ({bus.act_addr, bus.wgt_addr, bus.prm_addr, bus.mac_M0} !== '0) begin
         n_err++;
         $display("FAIL reset_addr: act %0d wgt %0d prm %0d M0 %0d want 0",
                  bus.act_addr, bus.wgt_addr, bus.prm_addr, bus.mac_M0);
      end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_single;
      for (int j = 0; j < 4; j++) begin act_mem[j] = 8'(j + 1); wgt_mem[j] = 8'sd1; end
      pm0[0] = 32'h4000_0000; pn[0] = 6'd0; pbias[0] = 0; pzo[0] = 0;
      go(4, 1, 0, 0);
      run(-1, 0, 0);
      check_results("t1", '{5});
      n_vec++;
      if (cyc_done != 14) begin n_err++; $display("FAIL t1_done_cycle: got %0d want 14", cyc_done); end
      n_vec++;
      if (busy_gap != 0 || after_busy !== 1'b0) begin
         n_err++; $display("FAIL t1_busy: low cycles %0d, after %b want 0/0", busy_gap, after_busy);
      end
      n_vec++;
      if (n_done != 1 || after_done !== 1'b0) begin
         n_err++; $display("FAIL t1_done_pulse: got %0d/%b want 1/0", n_done, after_done);
      end
      n_vec++;
      if (n_act != 4 || n_wre != 4 || n_en != 4) begin
         n_err++; $display("FAIL t1_beats: act %0d wgt %0d en %0d want 4", n_act, n_wre, n_en);
      end
   endtask

   task automatic test_k1;
      act_mem[0] = 8'sd10; wgt_mem[0] = 8'sd3; wgt_mem[1] = -8'sd3;
      for (int j = 0; j < 2; j++) begin
         pm0[j] = 32'h4000_0000; pn[j] = 6'd0; pbias[j] = 0; pzo[j] = 0;
      end
      go(1, 2, 0, 0);
      run(-1, 0, 0);
      check_results("t2", '{15, -15});
      n_vec++;
      if (n_cl_same != 2 || n_en != 2) begin
         n_err++; $display("FAIL t2_clear_last: same-beat %0d of %0d beats want 2 of 2", n_cl_same, n_en);
      end
      n_vec++;
      if (cyc_done != 13) begin n_err++; $display("FAIL t2_done_cycle: got %0d want 13", cyc_done); end
   endtask

   task automatic test_empty(input int k, input int n);
      go(k, n, 0, 0);
      run(-1, 0, 0);
      n_vec++;
      if (cyc_done != 0) begin n_err++; $display("FAIL empty_done_cycle k%0d n%0d: got %0d want 0", k, n, cyc_done); end
      n_vec++;
      if (n_act + n_wre + n_en + n_prm + rd_q.size() != 0 || busy_gap != 0) begin
         n_err++;
         $display("FAIL empty_activity k%0d n%0d: act %0d wgt %0d en %0d prm %0d res %0d busy_low %0d want 0",
                  k, n, n_act, n_wre, n_en, n_prm, rd_q.size(), busy_gap);
      end
      n_vec++;
      if (after_busy !== 1'b0 || after_done !== 1'b0) begin
         n_err++; $display("FAIL empty_after k%0d n%0d: busy %b done %b want 0", k, n, after_busy, after_done);
      end
   endtask

   // three channels: act {3,5,7} with Za=1 -> {2,4,6}
   task automatic load_t4;
      int w[9];
      w = '{1, 1, 1, 1, 0, -1, 2, 2, 2};
      act_mem[0] = 8'sd3; act_mem[1] = 8'sd5; act_mem[2] = 8'sd7;
      for (int j = 0; j < 9; j++) wgt_mem[j] = 8'(w[j]);
      pm0[0] = 32'h4000_0000; pn[0] = 6'd0; pbias[0] = 0;   pzo[0] = 0;
      pm0[1] = 32'h4000_0000; pn[1] = 6'd0; pbias[1] = 10;  pzo[1] = 5;
      pm0[2] = 32'h4000_0000; pn[2] = 6'd1; pbias[2] = -4;  pzo[2] = -3;
   endtask

   task automatic test_back_to_back;
      int bad;
      load_t4();
      go(3, 3, 1, 0);
      run(-1, 0, 0);
      check_results("t4", '{6, 8, 2});
      bad = 0;
      for (int j = 0; j < wa_q.size(); j++) if (wa_q[j] != j || aa_q[j] != j % 3) bad++;
      n_vec++;
      if (wa_q.size() != 9 || bad != 0) begin
         n_err++; $display("FAIL t4_wgt_addr: %0d reads, %0d out of order, want 9 reads 0..8", wa_q.size(), bad);
      end
      bad = 0;
      for (int j = 0; j < pa_q.size(); j++) if (pa_q[j] != j) bad++;
      n_vec++;
      if (pa_q.size() != 3 || bad != 0) begin
         n_err++; $display("FAIL t4_prm_addr: %0d reads, %0d wrong, want 3 reads 0,1,2", pa_q.size(), bad);
      end
      n_vec++;
      if (n_issue != 12) begin n_err++; $display("FAIL t4_issue_cycles: got %0d want 12", n_issue); end
      n_vec++;
      if (cyc_done != 21) begin n_err++; $display("FAIL t4_done_cycle: got %0d want 21", cyc_done); end
   endtask

   task automatic test_restart_ignored;
      load_t4();
      go(3, 3, 1, 0);
      run(2, 2, 1);
      check_results("t5", '{6, 8, 2});
      n_vec++;
      if (n_act != 9 || cyc_done != 21) begin
         n_err++; $display("FAIL t5_config_kept: act %0d done@%0d want 9 / 21", n_act, cyc_done);
      end
   endtask

   task automatic test_reset_mid;
      int quiet;
      load_t4();
      go(3, 2, 1, 0);
      repeat (6) @(negedge CLK);
      n_vec++;
      if (bus.act_re !== 1'b1 || bus.wgt_addr !== WA_W'(4) || bus.prm_addr !== CH_W'(1)) begin
         n_err++; $display("FAIL t6_pre_reset: act_re %b wgt_addr %0d prm_addr %0d want 1/4/1",
                           bus.act_re, bus.wgt_addr, bus.prm_addr);
      end
      RST = 1'b1;
      @(negedge CLK);
      n_vec++;
      if ({busy, done, bus.act_re, bus.wgt_re, bus.prm_re, bus.mac_En, bus.mac_clear,
           bus.mac_last, bus.res_we, bus.act_addr, bus.wgt_addr, bus.prm_addr} !== '0) begin
         n_err++; $display("FAIL t6_reset_outputs: busy %b act_re %b en %b wgt_addr %0d want all 0",
                           busy, bus.act_re, bus.mac_En, bus.wgt_addr);
      end
      RST = 1'b0;
      quiet = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge CLK);
         if (busy || bus.res_we || bus.act_re || bus.prm_re) quiet++;
      end
      n_vec++;
      if (quiet != 0) begin n_err++; $display("FAIL t6_idle_after_reset: %0d active cycles want 0", quiet); end
      go(3, 3, 1, 0);
      run(-1, 0, 0);
      check_results("t6", '{6, 8, 2});
   endtask

   initial begin
      test_reset();
      test_single();
      test_k1();
      test_empty(0, 3);
      test_empty(5, 0);
      test_back_to_back();
      test_restart_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
